ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, ...) to the keyboard over the shared open-drain ps2Ck/ps2DQ lines. It is the counterpart of the existing PS/2 keyboard receiver and sits beside it on the same two pins, using the same `ce` timebase. The host inhibits the bus, issues request-to-send, and shifts out start, 8 data bits, odd parity and stop on device-generated clocks. It then checks the device acknowledge bit.

## Interface
- `INHIBIT`, 100: ce ticks ps2Ck is held low before request-to-send; must represent ≥100 µs.
- `TIMEOUT`, 15000: ce ticks allowed between consecutive device falling edges, including the first, before aborting.
- `clock`  in  1  system clock; single clock domain.
- `nreset`  in  1  asynchronous, active-low reset.
- `ce`  in  1  sampling/timing enable; FSM and filter advance only when high.
- `ps2Ck`  inout  1  PS/2 clock; driven 0 or Z only.
- `ps2DQ`  inout  1  PS/2 data; driven 0 or Z only.
- `send`  in  1  one-clock request strobe.
- `data`  in  8  byte to send; sampled with `send`.
- `busy`  out  1  high from acceptance until return to IDLE.
- `done`  out  1  one-clock pulse: byte sent and ACK seen.
- `error`  out  1  one-clock pulse: no ACK or timeout.

## Operation
- Clock filter: 8-bit shift of raw ps2Ck per ce. Filtered clock goes 1 when all ones and 0 when all zeros; otherwise it holds. A 1→0 transition yields a one-ce falling-edge event. The filter samples the pin, so own drive is seen too; edges are used only after release.
- `send` is accepted on any clock with busy=0, independent of ce. It latches `data` and parity = ~^data, then enters INHIBIT. `send` with busy=1 is ignored.
- States:
  - IDLE: both lines Z.
  - INHIBIT: ps2Ck=0, counter runs INHIBIT ce ticks.
  - RTS: ps2DQ=0 (start bit); one ce later ps2Ck released, go SHIFT.
  - SHIFT: bit counter 0–10. Edge 1–8 drives data[0..7] LSB first, 0 as drive-low and 1 as Z. Edge 9 drives parity. Edge 10 releases ps2DQ (stop), go ACK.
  - ACK: on edge 11 sample ps2DQ. If 0, go WAIT; if 1, pulse error and go IDLE.
  - WAIT: wait filtered clock = 1 and ps2DQ = 1, then pulse done and go IDLE.
- Timeout counter reloads on each falling edge and on entry to SHIFT. Expiry in SHIFT/ACK/WAIT releases both lines, pulses error and returns to IDLE.
- Counter width: $clog2(max(INHIBIT,TIMEOUT)+1). Bit counter is 4 bits.
- The receiver also sees the device clocks during transmission; the top level gates receiver strobes with busy.

## Timing
- Reset: lines Z, busy=0, done=0, error=0, state IDLE, filtered clock=1, filter register all ones.
- nreset assertion mid-frame releases both lines immediately, asynchronously.
- busy rises the clock after accepted `send`. ps2Ck goes low on the first ce after that.
- ps2Ck low for exactly INHIBIT ce ticks. ps2DQ falls one ce before ps2Ck is released.
- Data changes within one ce of each filtered falling edge, i.e. 8 ce after the raw edge; device low phase must exceed this.
- done/error last one clock. busy falls on the same clock as the pulse. `send` is accepted the following clock.
- done and error are never asserted together.

## Structure
- Package `ps2_pkg`:
  - state enum (IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT);
  - constants `PS2_BITS=11` and `PS2_FILT=8`;
  - command constants 0xED, 0xF4, 0xFF.
- Sub-module `ps2_filter`: 8-sample clock filter with falling-edge output, shared with the receiver.

## Test plan
- Reset with ce=1 every clock → ps2Ck=Z, ps2DQ=Z, busy=0 held; no pulses.
- send 0xED, device model clocks 11 edges and acks on edge 11 → ps2Ck low 100 ce, data bits 1,0,1,1,0,1,1,1, parity 1, stop Z, done pulse, busy drops.
- send 0xF4 → bits 0,0,1,0,1,1,1,1, parity 0, done pulse.
- send 0x00, device leaves ps2DQ high at edge 11 → parity 1, error pulse, no done.
- send 0xFF, device never clocks → error pulse TIMEOUT ce ticks after RTS, lines Z.
- send while busy is ignored (the original byte completes), and nreset pulse mid-SHIFT → lines Z in same cycle, busy=0, next send restarts from INHIBIT.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame/filter sizes and
// the common keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_RTS     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_WAIT    = 3'd5
    } ps2_state_e;

    // Start + 8 data + parity + stop, the last device clock carrying the ACK.
    localparam int PS2_BITS = 11;

    // Number of consecutive equal clock samples needed to change the filtered clock.
    localparam int PS2_FILT = 8;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic ps2OddParity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 clock de-glitcher: the filtered clock only changes after PS2_FILT
// identical samples, and a one-ce strobe marks each filtered falling edge.
module ps2_filter
    import ps2_pkg::*;
(
    input  logic clock_i,
    input  logic nreset_i,
    input  logic ce_i,
    input  logic ckRaw_i,
    output logic ckFilt_o,
    output logic fall_o
);

    logic [PS2_FILT-1:0] shift_q;
    logic [PS2_FILT-1:0] shift_d;
    logic                filt_q;
    logic                filt_d;

    // Shift in one raw sample per ce and update the filtered level on a unanimous history.
    always_comb begin
        shift_d = shift_q;
        filt_d  = filt_q;
        if (ce_i) begin
            shift_d = {shift_q[PS2_FILT-2:0], ckRaw_i};
            if (&shift_d) begin
                filt_d = 1'b1;
            end else if (~|shift_d) begin
                filt_d = 1'b0;
            end
        end
    end

    // Sample history and filtered level; an idle bus is high, so reset to all ones.
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            shift_q <= '1;
            filt_q  <= 1'b1;
        end else begin
            shift_q <= shift_d;
            filt_q  <= filt_d;
        end
    end

    assign ckFilt_o = filt_q;
    assign fall_o   = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// one command byte out on device clocks and checks the device acknowledge.
// Both lines are open drain: this block only ever pulls them low or releases them.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT = 100,
    parameter int TIMEOUT = 15000
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       ce,
    inout  wire        ps2Ck,
    inout  wire        ps2DQ,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_MAX = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       EDGE_STOP = 4'(PS2_BITS - 1);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             ckLow_q, ckLow_d;
    logic             dqLow_q, dqLow_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       dqSync_q;

    logic       ckFilt;
    logic       fall;
    logic [3:0] edgeNum;
    logic       dqIn;

    ps2_filter u_filter (
        .clock_i  (clock),
        .nreset_i (nreset),
        .ce_i     (ce),
        .ckRaw_i  (ps2Ck),
        .ckFilt_o (ckFilt),
        .fall_o   (fall)
    );

    assign edgeNum = bitCnt_q + 4'd1;
    assign dqIn    = dqSync_q[1];

    // Bring the asynchronous data pin into the clock domain before it is looked at.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            dqSync_q <= 2'b11;
        end else begin
            dqSync_q <= {dqSync_q[0], ps2DQ};
        end
    end

    // Next-state, line drive and counters; the shared counter times inhibit, then device silence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        ckLow_d  = ckLow_q;
        dqLow_d  = dqLow_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ckLow_d = 1'b0;
                dqLow_d = 1'b0;
                if (send) begin
                    shift_d  = data;
                    parity_d = ps2OddParity(data);
                    cnt_d    = '0;
                    state_d  = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (ce) begin
                    ckLow_d = 1'b1;
                    if (cnt_q == INH_LAST) begin
                        dqLow_d = 1'b1;
                        state_d = ST_RTS;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_RTS: begin
                if (ce) begin
                    ckLow_d  = 1'b0;
                    cnt_d    = '0;
                    bitCnt_d = 4'd0;
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (fall) begin
                    cnt_d    = '0;
                    bitCnt_d = edgeNum;
                    if (edgeNum <= 4'd8) begin
                        dqLow_d = ~shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end else if (edgeNum == 4'd9) begin
                        dqLow_d = ~parity_q;
                    end else if (edgeNum == EDGE_STOP) begin
                        dqLow_d = 1'b0;
                        state_d = ST_ACK;
                    end
                end else if (ce) begin
                    if (cnt_q == TO_LAST) begin
                        ckLow_d = 1'b0;
                        dqLow_d = 1'b0;
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_ACK: begin
                if (fall) begin
                    cnt_d = '0;
                    if (!dqIn) begin
                        state_d = ST_WAIT;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (ce) begin
                    if (cnt_q == TO_LAST) begin
                        ckLow_d = 1'b0;
                        dqLow_d = 1'b0;
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_WAIT: begin
                if (ce && ckFilt && dqIn) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (ce) begin
                    if (cnt_q == TO_LAST) begin
                        ckLow_d = 1'b0;
                        dqLow_d = 1'b0;
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                ckLow_d = 1'b0;
                dqLow_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset releases both lines without waiting for a clock.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitCnt_q <= 4'd0;
            shift_q  <= 8'h00;
            parity_q <= 1'b0;
            ckLow_q  <= 1'b0;
            dqLow_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            ckLow_q  <= ckLow_d;
            dqLow_q  <= dqLow_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign ps2Ck = ckLow_q ? 1'b0 : 1'bz;
    assign ps2DQ = dqLow_q ? 1'b0 : 1'bz;

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// while a scoreboard monitor matches each done/error pulse against the
// outcome and frame predicted when the byte was issued.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIB = 100;
    localparam int TOUT  = 15000;

    logic       clock;
    logic       nreset;
    logic       ce;
    logic       send;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       error;
    logic       devCk;
    logic       devDq;
    wire        ps2Ck;
    wire        ps2DQ;

    typedef struct {
        logic [7:0] b;
        logic       expDone;
        logic       checkFrame;
        logic       checkTimeout;
    } exp_t;

    exp_t        expQ[$];
    int          checks;
    int          errors;
    int          ceDiv;
    int          cycleCnt;
    int          releaseCycle;
    logic [9:0]  capBits;
    logic        pulseSeen;

    assign ps2Ck = devCk ? 1'b0 : 1'bz;
    assign ps2DQ = devDq ? 1'b0 : 1'bz;
    pullup (ps2Ck);
    pullup (ps2DQ);

    ps2_host_tx #(.INHIBIT(INHIB), .TIMEOUT(TOUT)) dut (
        .clock  (clock),
        .nreset (nreset),
        .ce     (ce),
        .ps2Ck  (ps2Ck),
        .ps2DQ  (ps2DQ),
        .send   (send),
        .data   (data),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    // 100 MHz system clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Free-running cycle counter used to time the abort.
    initial begin
        cycleCnt = 0;
        forever begin
            @(posedge clock);
            cycleCnt++;
        end
    end

    // Periodic ce: high once every ceDiv clocks.
    initial begin
        int k;
        k = 0;
        ce = 1'b1;
        forever begin
            @(negedge clock);
            k++;
            ce = ((k % ceDiv) == 0);
        end
    end

    // Hard stop if the run hangs somewhere unexpected.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference frame as the device should see it: data LSB first, odd parity, stop.
    function automatic logic [9:0] refFrame(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = (((b >> i) & 8'd1) != 0);
            if (f[i]) ones++;
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // Scoreboard monitor: every done/error pulse pops one prediction.
    always @(negedge clock) begin
        exp_t e;
        if (nreset) begin
            if (pulseSeen) begin
                checkOutput("pulseWidth", int'(done | error), 0);
            end
            pulseSeen <= done | error;
            if (done || error) begin
                checkOutput("doneErrorExclusive", int'(done & error), 0);
                checkOutput("busyWithPulse", int'(busy), 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedPulse", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("outcomeDone_%02h", e.b), int'(done), int'(e.expDone));
                    if (e.checkFrame) begin
                        checkOutput($sformatf("frame_%02h", e.b), int'(capBits), int'(refFrame(e.b)));
                    end
                    if (e.checkTimeout) begin
                        checkOutput("timeoutDelay", cycleCnt - releaseCycle, TOUT * ceDiv);
                    end
                end
            end
        end else begin
            pulseSeen <= 1'b0;
        end
    end

    // Device model. mode 0: clocks 11 edges and ACKs; 1: clocks but no ACK; 2: silent.
    // abortEdge stops right after releasing the clock of that edge; busySend pokes send mid-frame.
    task automatic runDevice(input int mode, input int abortEdge, input bit busySend, input logic [7:0] b);
        int t;
        int lowCnt;
        int bothLow;
        int half;
        half = 15 * ceDiv;
        t = 0;
        while (ps2Ck !== 1'b0 && t < 1000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 1000) begin
            checkOutput("inhibitSeen", 0, 1);
            return;
        end
        lowCnt = 0;
        bothLow = 0;
        while (ps2Ck === 1'b0 && lowCnt < 5000) begin
            lowCnt++;
            if (ps2DQ === 1'b0) bothLow++;
            @(negedge clock);
        end
        releaseCycle = cycleCnt;
        checkOutput("inhibitLen", lowCnt, INHIB * ceDiv);
        checkOutput("rtsLead", bothLow, ceDiv);
        checkOutput("startBit", int'(ps2DQ), 0);
        if (mode == 2) return;
        repeat (half) @(negedge clock);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && mode == 0) devDq = 1'b1;
            devCk = 1'b1;
            repeat (half) @(negedge clock);
            devCk = 1'b0;
            if (e == 11) devDq = 1'b0;
            if (e <= 10) capBits[e-1] = ps2DQ;
            if (e == abortEdge) return;
            if (busySend && e == 5) begin
                send = 1'b1;
                data = ~b;
                @(negedge clock);
                send = 1'b0;
                repeat (half - 1) @(negedge clock);
            end else begin
                repeat (half) @(negedge clock);
            end
        end
    endtask

    // Issue one byte, record its prediction, play the device, then wait for idle.
    task automatic applyStimulus(input logic [7:0] b, input int mode, input bit busySend);
        exp_t e;
        int t;
        int limit;
        e.b            = b;
        e.expDone      = (mode == 0);
        e.checkFrame   = (mode != 2);
        e.checkTimeout = (mode == 2);
        expQ.push_back(e);
        capBits = '0;
        @(negedge clock);
        send = 1'b1;
        data = b;
        @(negedge clock);
        send = 1'b0;
        data = 8'($urandom);
        checkOutput("busyRise", int'(busy), 1);
        checkOutput("ckBeforeCe", int'(ps2Ck), 1);
        runDevice(mode, 0, busySend, b);
        limit = (TOUT + 500) * ceDiv;
        t = 0;
        while (busy && t < limit) begin
            @(negedge clock);
            t++;
        end
        checkOutput("busyFallInTime", int'(t < limit), 1);
        repeat (5) @(negedge clock);
        checkOutput("idleLines", int'({ps2Ck, ps2DQ, busy}), 3'b110);
    endtask

    // Pull nreset in the middle of SHIFT while the host is driving a 0 bit.
    task automatic resetMidShift(input logic [7:0] b);
        capBits = '0;
        @(negedge clock);
        send = 1'b1;
        data = b;
        @(negedge clock);
        send = 1'b0;
        runDevice(0, 4, 1'b0, b);
        checkOutput("dqDrivenBeforeReset", int'(ps2DQ), 0);
        nreset = 1'b0;
        #1;
        checkOutput("resetReleasesLines", int'({ps2Ck, ps2DQ, busy}), 3'b110);
        @(negedge clock);
        nreset = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("idleAfterReset", int'({ps2Ck, ps2DQ, busy, done, error}), 5'b11000);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ceDiv     = 1;
        nreset    = 1'b0;
        send      = 1'b0;
        data      = 8'h00;
        devCk     = 1'b0;
        devDq     = 1'b0;
        capBits   = '0;
        pulseSeen = 1'b0;
        releaseCycle = 0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("resetIdle", int'({ps2Ck, ps2DQ, busy, done, error}), 5'b11000);
        end
        nreset = 1'b1;
        repeat (3) @(negedge clock);

        $display("[TB] directed commands, ce every clock");
        applyStimulus(PS2_CMD_SET_LED, 0, 1'b0);
        applyStimulus(PS2_CMD_ENABLE, 0, 1'b0);
        applyStimulus(8'h00, 1, 1'b0);
        applyStimulus(PS2_CMD_RESET, 2, 1'b0);
        applyStimulus(PS2_CMD_SET_LED, 0, 1'b1);
        resetMidShift(8'h00);
        applyStimulus(PS2_CMD_RESET, 0, 1'b0);

        $display("[TB] random bytes, ce every other clock");
        ceDiv = 2;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'($urandom), int'($urandom_range(0, 1)), 1'b0);
        end

        repeat (10) @(negedge clock);
        checkOutput("scoreboardEmpty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
